// File: rtl/display_request_arbiter_if.sv
// Display request bus: requesters and the 7-segment driver on one side,
// the display arbiter on the other.
// The arbiter connects through the slave modport; the environment
// (requesters plus driver) uses the master modport.
interface display_request_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int WIDTH = 32
);
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       REQ;
    logic [N_REQ*WIDTH-1:0] BIN_REQ;
    logic [N_REQ-1:0]       GRANT;
    logic [WIDTH-1:0]       BIN_OUT;
    logic                   DEC_TRIGGER;
    logic                   DEC_DONE;
    logic [ID_W-1:0]        ACTIVE_ID;
    logic                   BUSY;
    logic                   TIMEOUT_ERR;

    modport slave (
        input  REQ, BIN_REQ, DEC_DONE,
        output GRANT, BIN_OUT, DEC_TRIGGER, ACTIVE_ID, BUSY, TIMEOUT_ERR
    );

    modport master (
        output REQ, BIN_REQ, DEC_DONE,
        input  GRANT, BIN_OUT, DEC_TRIGGER, ACTIVE_ID, BUSY, TIMEOUT_ERR
    );
endinterface

// File: rtl/display_request_arbiter.sv
// display_request_arbiter: shares one 7-segment driver among N_REQ requesters.
// It grants one requester, latches its value onto BIN_OUT, and pulses
// DEC_TRIGGER. It then waits for DEC_DONE, or for a timeout, and holds the
// value for MIN_HOLD cycles before it serves the next requester.
// Optional build macro DISP_ARB_FIXED_PRIO_EN: when it is defined, the
// lowest requesting index always wins. By default the arbiter uses round
// robin with a rotating pointer.
module display_request_arbiter #(
    parameter int N_REQ    = 3,
    parameter int WIDTH    = 32,
    parameter int MIN_HOLD = 16,
    parameter int TIMEOUT  = 64
) (
    input  logic                       CLK,
    input  logic                       RESET,
    display_request_arbiter_if.slave   bus
);
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WCNT_W = $clog2(TIMEOUT + 1);
    localparam int HCNT_W = $clog2(MIN_HOLD + 1);
    localparam logic [N_REQ-1:0] ONE_HOT_LSB = N_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TRIG = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t              r_state;
    logic [N_REQ-1:0]    r_grant;
    logic [WIDTH-1:0]    r_bin_out;
    logic                r_dec_trigger;
    logic [ID_W-1:0]     r_active_id;
    logic                r_busy;
    logic                r_timeout_err;
    logic [WCNT_W-1:0]   r_wait_cnt;
    logic [HCNT_W-1:0]   r_hold_cnt;

    logic [ID_W-1:0]     w_winner;
    logic                w_found;
    logic [N_REQ-1:0]    w_onehot;
    logic [WIDTH-1:0]    w_bin_sel;

`ifdef DISP_ARB_FIXED_PRIO_EN
    // Fixed priority: scan downward so the lowest asserted index overwrites last.
    always_comb begin
        w_winner = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_winner = bus.REQ[i] ? ID_W'(i) : w_winner;
        end
    end
`else
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     w_next_ptr;
    int                  w_rr_idx;

    // Round robin: the first asserted request at or above the pointer wins; the search wraps at N_REQ-1.
    always_comb begin
        w_winner = '0;
        w_rr_idx = 0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            w_rr_idx = ((int'(r_rr_ptr) + off) >= N_REQ) ? (int'(r_rr_ptr) + off - N_REQ)
                                                         : (int'(r_rr_ptr) + off);
            w_winner = bus.REQ[w_rr_idx] ? ID_W'(w_rr_idx) : w_winner;
        end
    end

    assign w_next_ptr = (w_winner == ID_W'(N_REQ - 1)) ? '0 : (w_winner + ID_W'(1));

    // The pointer moves to the requester after the one just granted, so it passes over idle requesters.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rr_ptr <= '0;
        end else if ((r_state == S_IDLE) && w_found) begin
            r_rr_ptr <= w_next_ptr;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end
`endif

    assign w_found   = |bus.REQ;
    assign w_onehot  = ONE_HOT_LSB << w_winner;
    assign w_bin_sel = bus.BIN_REQ[int'(w_winner) * WIDTH +: WIDTH];

    // Main control FSM. Every output comes from a register, and REQ is looked at only in IDLE.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_bin_out     <= '0;
            r_dec_trigger <= 1'b0;
            r_active_id   <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_wait_cnt    <= '0;
            r_hold_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant     <= w_onehot;
                        r_bin_out   <= w_bin_sel;
                        r_active_id <= w_winner;
                        r_busy      <= 1'b1;
                        r_state     <= S_TRIG;
                    end else begin
                        r_grant     <= '0;
                    end
                end
                // DEC_DONE seen here is left over from the previous conversion and is not examined.
                S_TRIG: begin
                    r_grant       <= '0;
                    r_dec_trigger <= 1'b1;
                    r_wait_cnt    <= '0;
                    r_state       <= S_WAIT;
                end
                // Done is checked before the timeout, so a done on the timeout cycle wins.
                S_WAIT: begin
                    r_dec_trigger <= 1'b0;
                    if (bus.DEC_DONE) begin
                        r_hold_cnt <= HCNT_W'(MIN_HOLD);
                        r_state    <= S_HOLD;
                    end else if (r_wait_cnt == WCNT_W'(TIMEOUT - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_hold_cnt    <= HCNT_W'(MIN_HOLD);
                        r_state       <= S_HOLD;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (r_hold_cnt <= HCNT_W'(1)) begin
                        r_hold_cnt <= '0;
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - HCNT_W'(1);
                    end
                end
                default: begin
                    r_grant       <= '0;
                    r_dec_trigger <= 1'b0;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.GRANT       = r_grant;
    assign bus.BIN_OUT     = r_bin_out;
    assign bus.DEC_TRIGGER = r_dec_trigger;
    assign bus.ACTIVE_ID   = r_active_id;
    assign bus.BUSY        = r_busy;
    assign bus.TIMEOUT_ERR = r_timeout_err;
endmodule

// File: tb/tb_display_request_arbiter.sv
// Testbench for display_request_arbiter.
// A scoreboard queue holds the expected grants: the stimulus pushes entries
// and a negedge monitor pops them whenever GRANT fires.
// Timing checks compare cycle stamps against hand-derived latencies.
// Cycle stamps count the posedge+1 sample points.
module tb_display_request_arbiter;
    localparam int N  = 3;
    localparam int W  = 32;
    localparam int MH = 4;
    localparam int TO = 8;

    typedef struct {
        int          id;
        logic [31:0] val;
    } exp_t;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    display_request_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    display_request_arbiter #(.N_REQ(N), .WIDTH(W), .MIN_HOLD(MH), .TIMEOUT(TO)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // stimulus/driver state
    int   cyc = 0, n_grants = 0, last_grant_cyc = 0, prev_grant_cyc = 0;
    int   trig_cyc = 0, idle_cyc = 0, err_cyc = 0, trig_count = 0;
    int   done_delay = 1, dn_cnt = 0;
    logic done_level = 1'b0, dn_arm = 1'b0, rearm = 1'b0;
    logic busy_prev = 1'b0, err_prev = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_bin(input int i, input logic [31:0] v);
        bus.BIN_REQ[i*W +: W] = v;
    endtask

    task automatic push(input int id, input logic [31:0] v);
        exp_t e;
        e.id  = id;
        e.val = v;
        sb.push_back(e);
    endtask

    // one clock: requesters drop (or rearm) on grant, driver model answers DEC_TRIGGER
    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (bus.GRANT[i]) begin
                bus.REQ[i]     = rearm;
                n_grants++;
                prev_grant_cyc = last_grant_cyc;
                last_grant_cyc = cyc;
            end
        end
        if (!done_level && bus.DEC_DONE) bus.DEC_DONE = 1'b0;
        if (bus.DEC_TRIGGER) begin
            trig_cyc = cyc;
            dn_cnt   = 0;
            dn_arm   = 1'b1;
            if (done_level) bus.DEC_DONE = 1'b0;
        end else if (dn_arm) begin
            dn_cnt++;
            if (done_delay > 0 && dn_cnt == done_delay) begin
                bus.DEC_DONE = 1'b1;
                dn_arm       = 1'b0;
            end
        end
        if (busy_prev && !bus.BUSY) idle_cyc = cyc;
        if (!err_prev && bus.TIMEOUT_ERR) err_cyc = cyc;
        busy_prev = bus.BUSY;
        err_prev  = bus.TIMEOUT_ERR;
    endtask

    // wait for one transaction to start (if not already busy) and return to idle
    task automatic wait_txn(input string nm);
        int n = 0;
        while (!bus.BUSY && n < 10) begin step(); n++; end
        while (bus.BUSY && n < 200) begin step(); n++; end
        chk({nm, "_completes"}, {63'd0, (n < 200) && !bus.BUSY}, 64'd1);
    endtask

    task automatic wait_grant(input string nm);
        int g0 = n_grants;
        int n  = 0;
        while (n_grants == g0 && n < 20) begin step(); n++; end
        chk({nm, "_granted"}, {63'd0, n_grants != g0}, 64'd1);
    endtask

    // monitor: pop expected grant on every GRANT pulse, check trigger follows a grant
    int          mon_cyc = 0, mon_last_g = -1;
    logic [N-1:0] mon_prev_grant = '0;
    exp_t        mon_e;
    always @(negedge CLK) begin
        if (!RESET) begin
            mon_prev_grant = '0;
            mon_last_g     = -1;
        end else begin
            mon_cyc++;
            if (bus.GRANT != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_grant", 64'(bus.GRANT), 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("grant_vec", 64'(bus.GRANT), 64'(3'b001 << mon_e.id));
                    chk("bin_out", 64'(bus.BIN_OUT), 64'(mon_e.val));
                    chk("active_id", 64'(bus.ACTIVE_ID), 64'(mon_e.id));
                end
                if (mon_last_g >= 0) begin
                    chk("grant_spacing", {63'd0, (mon_cyc - mon_last_g) >= (MH + 3)}, 64'd1);
                end
                mon_last_g = mon_cyc;
            end
            if (bus.DEC_TRIGGER) begin
                trig_count++;
                chk("trig_after_grant", {63'd0, mon_prev_grant != '0}, 64'd1);
            end
            mon_prev_grant = bus.GRANT;
        end
    end

    initial begin
        int t0;
        bus.REQ      = '0;
        bus.BIN_REQ  = '0;
        bus.DEC_DONE = 1'b0;

        // ---- reset state ----
        #2 RESET = 1'b0;
        #1;
        chk("rst_grant", 64'(bus.GRANT), 64'd0);
        chk("rst_bin", 64'(bus.BIN_OUT), 64'd0);
        chk("rst_trig", 64'(bus.DEC_TRIGGER), 64'd0);
        chk("rst_id", 64'(bus.ACTIVE_ID), 64'd0);
        chk("rst_busy", 64'(bus.BUSY), 64'd0);
        chk("rst_err", 64'(bus.TIMEOUT_ERR), 64'd0);
        #20 RESET = 1'b1;

        // ---- RR fairness: REQ=111 rearmed after each grant ----
        set_bin(0, 32'h0000_0100);
        set_bin(1, 32'h0000_0201);
        set_bin(2, 32'h0000_0302);
        done_level = 1'b0;
        done_delay = 1;
`ifdef DISP_ARB_FIXED_PRIO_EN
        for (int k = 0; k < 6; k++) push(0, 32'h0000_0100);
`else
        for (int k = 0; k < 6; k++) push(k % 3, 32'h0000_0100 + 32'(k % 3) * 32'h101);
`endif
        rearm   = 1'b1;
        bus.REQ = 3'b111;
        begin
            int g0 = n_grants;
            int n  = 0;
            while (n_grants < g0 + 6 && n < 200) begin step(); n++; end
            chk("rr_six_grants", 64'(n_grants - g0), 64'd6);
        end
        rearm   = 1'b0;
        bus.REQ = '0;
        chk("rr_spacing", 64'(last_grant_cyc - prev_grant_cyc), 64'(1 + 3 + MH));
        wait_txn("rr_tail");

        // ---- single request, done 5 cycles after trigger ----
        set_bin(0, 32'd99);
        done_delay = 5;
        push(0, 32'd99);
        t0      = trig_count;
        bus.REQ = 3'b001;
        wait_txn("single");
        chk("single_trig_lat", 64'(trig_cyc - last_grant_cyc), 64'd1);
        chk("single_busy_len", 64'(idle_cyc - last_grant_cyc), 64'(5 + 2 + MH));
        chk("single_trig_cnt", 64'(trig_count - t0), 64'd1);
        chk("single_bin_hold", 64'(bus.BIN_OUT), 64'd99);
        chk("single_id_hold", 64'(bus.ACTIVE_ID), 64'd0);
        chk("single_no_err", 64'(bus.TIMEOUT_ERR), 64'd0);

        // ---- corner: level DEC_DONE left high through TRIG, then done on the timeout cycle ----
        done_level = 1'b1;
        done_delay = 3;
        set_bin(0, 32'hA5A5_0003);
        push(0, 32'hA5A5_0003);
        bus.REQ = 3'b001;
        wait_txn("lvl_first");
        chk("lvl_first_len", 64'(idle_cyc - last_grant_cyc), 64'(3 + 2 + MH));
        chk("lvl_done_stale", 64'(bus.DEC_DONE), 64'd1);
        done_delay = TO - 1;
        set_bin(0, 32'hA5A5_0007);
        push(0, 32'hA5A5_0007);
        bus.REQ = 3'b001;
        wait_txn("edge_to");
        chk("edge_to_len", 64'(idle_cyc - last_grant_cyc), 64'(TO - 1 + 2 + MH));
        chk("edge_to_no_err", 64'(bus.TIMEOUT_ERR), 64'd0);
        done_level   = 1'b0;
        bus.DEC_DONE = 1'b0;

        // ---- timeout: DEC_DONE never comes ----
        done_delay = -1;
        set_bin(1, 32'hDEAD_0001);
        push(1, 32'hDEAD_0001);
        bus.REQ = 3'b010;
        wait_txn("timeout");
        chk("to_err_set", 64'(bus.TIMEOUT_ERR), 64'd1);
        chk("to_err_lat", 64'(err_cyc - trig_cyc), 64'(TO));
        chk("to_busy_len", 64'(idle_cyc - last_grant_cyc), 64'(TO + 1 + MH));
        dn_arm     = 1'b0;
        done_delay = 2;
        set_bin(2, 32'hBEEF_0002);
        push(2, 32'hBEEF_0002);
        bus.REQ = 3'b100;
        wait_txn("after_to");
        chk("to_err_sticky", 64'(bus.TIMEOUT_ERR), 64'd1);

        // ---- no preemption: REQ[2] raised during WAIT of requester 0 ----
        done_delay = 5;
        set_bin(0, 32'h0000_0A00);
        set_bin(2, 32'h0000_0A02);
        push(0, 32'h0000_0A00);
        push(2, 32'h0000_0A02);
        bus.REQ = 3'b001;
        wait_grant("np0");
        repeat (3) step();
        bus.REQ[2] = 1'b1;
        wait_txn("np0");
        wait_txn("np2");
        chk("np_spacing", 64'(last_grant_cyc - prev_grant_cyc), 64'(5 + 3 + MH));

        // ---- reset mid-WAIT ----
        done_delay = -1;
        set_bin(1, 32'h1234_5678);
        push(1, 32'h1234_5678);
        bus.REQ = 3'b010;
        wait_grant("mr");
        repeat (4) step();
        chk("mr_busy_before", 64'(bus.BUSY), 64'd1);
        chk("mr_err_before", 64'(bus.TIMEOUT_ERR), 64'd1);
        #2 RESET = 1'b0;
        #1;
        chk("mr_grant", 64'(bus.GRANT), 64'd0);
        chk("mr_bin", 64'(bus.BIN_OUT), 64'd0);
        chk("mr_trig", 64'(bus.DEC_TRIGGER), 64'd0);
        chk("mr_id", 64'(bus.ACTIVE_ID), 64'd0);
        chk("mr_busy", 64'(bus.BUSY), 64'd0);
        chk("mr_err", 64'(bus.TIMEOUT_ERR), 64'd0);
        #2 RESET = 1'b1;
        busy_prev  = 1'b0;
        err_prev   = 1'b0;
        dn_arm     = 1'b0;
        done_delay = 2;
        set_bin(0, 32'h0000_00C0);
        set_bin(2, 32'h0000_00C2);
        push(0, 32'h0000_00C0);
        push(2, 32'h0000_00C2);
        bus.REQ = 3'b101;
        wait_txn("post_rst0");
        wait_txn("post_rst2");
        chk("post_rst_err", 64'(bus.TIMEOUT_ERR), 64'd0);

        repeat (2) step();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
